seq_det_prog: RTL and testbench
===============================

Name: seq_det_prog

Overview:
Parametrised serial pattern detector. It detects a run-time programmable PAT_W-bit pattern on a qualified 1-bit input stream. Overlapping or non-overlapping detection is selectable, and a saturating match counter is included. Successor to the fixed "101" Moore detector; it sits on serial control/test links and feeds det_o to interrupt or trigger logic.

Parameters:
PAT_W, 3, pattern length in bits; legal range 2..16
PAT_RST, 3'b101 (PAT_W bits), pattern value loaded on reset
CNT_W, 8, width of the match counter

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
seq_in  input  1  serial data bit
seq_valid  input  1  seq_in is sampled only when high
pat_load  input  1  load pat_in into the pattern register
pat_in  input  PAT_W  new pattern; bit PAT_W-1 is the first bit received, bit 0 the last
overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping
cnt_clr  input  1  clear the match counter
det_o  output  1  registered one-cycle detect pulse
match_cnt  output  CNT_W  saturating count of detections
cnt_sat  output  1  high while match_cnt is all-ones

Behaviour:
- Reset: clock is clock; reset is reset, synchronous, active-high. On reset: pattern register = PAT_RST, history = 0, fill = 0, det_o = 0, match_cnt = 0, cnt_sat = 0. Reset has priority over every other input.
- Internal state:
  - hist[PAT_W-1:0]: shift register, shifts left, new bit enters at bit 0.
  - fill: counter 0..PAT_W-1. Counts valid bits accepted since the last reset, load or non-overlap match.
  - Two-state FSM: FILL (fill < PAT_W-1) and ARMED (fill == PAT_W-1).
- Sample cycle (seq_valid=1, pat_load=0):
  - candidate = {hist[PAT_W-2:0], seq_in}; hist <= candidate.
  - match = ARMED && (candidate == pattern).
  - FILL: fill increments; it moves to ARMED when it reaches PAT_W-1.
  - ARMED with no match, or match with overlap_en=1: stay ARMED, fill unchanged.
  - ARMED with match and overlap_en=0: fill <= 0, hist <= 0, go to FILL.
- No-sample cycle (seq_valid=0): hist, fill and FSM hold; seq_in is ignored.
- det_o:
  - Asserted for exactly one cycle, in the cycle after the edge that sampled the completing bit (latency 1).
  - 0 on every other cycle, including cycles with seq_valid=0.
  - Back-to-back pulses are allowed in overlap mode, e.g. pattern 11 on input 1,1,1.
- Pattern load (pat_load=1):
  - pattern <= pat_in; hist and fill cleared; FSM to FILL; det_o=0 next cycle.
  - A sample offered in the same cycle is discarded.
  - match_cnt is not affected.
- overlap_en is sampled at the match edge and may change at any time.
- match_cnt:
  - Increments by 1 on each match, saturating at 2^CNT_W-1 (no wrap).
  - cnt_sat = (match_cnt == all-ones), registered alongside match_cnt.
  - cnt_clr forces match_cnt to 0 and cnt_sat to 0. If a match occurs in the same cycle, clear wins and the result is 0; det_o still pulses.
- Reset mid-sequence discards partial history; no detection can span a reset or a pattern load.
- The pattern register has no reset-to-zero ambiguity; an all-zero pattern is legal and matches PAT_W consecutive valid zeros.

Test Plan:
1. Defaults (101), overlap_en=1, valid bits 1,0,1,0,1 -> det_o pulses after 3rd and 5th bits; match_cnt=2.
2. Same stream, overlap_en=0 -> single pulse after 3rd bit; match_cnt=1. Then input 1,0,1 -> second pulse; match_cnt=2.
3. Bits 1,0,1 with seq_valid=0 gap cycles between them, seq_in toggled during the gaps -> exactly one pulse, one cycle after the last valid bit.
4. pat_load with pat_in=3'b110 asserted together with seq_valid=1, seq_in=1 -> that bit discarded. Then 1,1,0 -> pulse; prior 1,0,1 stream does not fire after the load.
5. CNT_W=2, overlap, 5 matches of 101 -> match_cnt 1,2,3,3,3; cnt_sat=1 from the 3rd match. cnt_clr coincident with the 6th match -> match_cnt=0, cnt_sat=0, det_o=1.
6. Bits 1,0, reset for 1 cycle, then 1 -> no pulse; outputs read 0 throughout and after reset. Then 0,1 -> pulse.

Source files
------------

// File: rtl/seq_det_prog.sv
// Programmable serial pattern detector with selectable overlap
// and a saturating match counter.
module seq_det_prog #(
  parameter int              PAT_W   = 3,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(3'b101),
  parameter int              CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             seq_in,
  input  logic             seq_valid,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap_en,
  input  logic             cnt_clr,
  output logic             det_o,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int FW = $clog2(PAT_W);
  localparam logic [FW-1:0] LAST = FW'(PAT_W - 1);

  typedef enum logic {FILL, ARMED} state_t;

  state_t           state, state_nx;
  logic [PAT_W-1:0] pattern;
  logic [PAT_W-1:0] hist, hist_nx, cand;
  logic [FW-1:0]    fill, fill_nx;
  logic             match;
  logic [CNT_W-1:0] cnt_nx;

  always_comb begin
    cand     = {hist[PAT_W-2:0], seq_in};
    match    = 1'b0;
    state_nx = state;
    hist_nx  = hist;
    fill_nx  = fill;
    if (pat_load) begin
      state_nx = FILL;
      hist_nx  = '0;
      fill_nx  = '0;
    end else if (seq_valid) begin
      hist_nx = cand;
      unique case (state)
        FILL: begin
          fill_nx = fill + 1'b1;
          if (fill_nx == LAST)
            state_nx = ARMED;
        end
        ARMED: begin
          if (cand == pattern) begin
            match = 1'b1;
            // non-overlap restarts the search from an empty history
            if (!overlap_en) begin
              fill_nx  = '0;
              hist_nx  = '0;
              state_nx = FILL;
            end
          end
        end
        default: state_nx = FILL;
      endcase
    end
  end

  always_comb begin
    cnt_nx = match_cnt;
    if (cnt_clr)
      cnt_nx = '0;
    else if (match && !(&match_cnt))
      cnt_nx = match_cnt + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= FILL;
      pattern   <= PAT_RST;
      hist      <= '0;
      fill      <= '0;
      det_o     <= 1'b0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else begin
      state     <= state_nx;
      hist      <= hist_nx;
      fill      <= fill_nx;
      det_o     <= match;
      match_cnt <= cnt_nx;
      cnt_sat   <= &cnt_nx;
      if (pat_load)
        pattern <= pat_in;
    end
  end

endmodule

// File: tb/tb_seq_det_prog.sv
// Random + directed bench for seq_det_prog against a queue-based
// reference model; two instances cover CNT_W=8 and CNT_W=2.
module tb_seq_det_prog;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       seq_in = 1'b0;
  logic       seq_valid = 1'b0;
  logic       pat_load = 1'b0;
  logic [2:0] pat_in = 3'b000;
  logic       overlap_en = 1'b1;
  logic       cnt_clr = 1'b0;

  logic       det_a, sat_a;
  logic [7:0] cnt_a;
  logic       det_b, sat_b;
  logic [1:0] cnt_b;

  int total = 0;
  int bad = 0;

  seq_det_prog dut_a (
    .clock(clock), .reset(reset),
    .seq_in(seq_in), .seq_valid(seq_valid),
    .pat_load(pat_load), .pat_in(pat_in),
    .overlap_en(overlap_en), .cnt_clr(cnt_clr),
    .det_o(det_a), .match_cnt(cnt_a), .cnt_sat(sat_a)
  );

  seq_det_prog #(.CNT_W(2)) dut_b (
    .clock(clock), .reset(reset),
    .seq_in(seq_in), .seq_valid(seq_valid),
    .pat_load(pat_load), .pat_in(pat_in),
    .overlap_en(overlap_en), .cnt_clr(cnt_clr),
    .det_o(det_b), .match_cnt(cnt_b), .cnt_sat(sat_b)
  );

  always #5 clock = ~clock;

  // reference model state
  bit [2:0] m_pat;
  bit       m_q[$];
  bit       m_det;
  int       m_cnt_a, m_cnt_b;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_pat = 3'b101;
      m_q.delete();
      m_det = 0;
      m_cnt_a = 0;
      m_cnt_b = 0;
      return;
    end
    m_det = 0;
    if (pat_load) begin
      m_pat = pat_in;
      m_q.delete();
    end else if (seq_valid) begin
      m_q.push_back(seq_in);
      if (m_q.size() > 3) void'(m_q.pop_front());
      if (m_q.size() == 3 && {m_q[0], m_q[1], m_q[2]} == m_pat) begin
        m_det = 1;
        if (m_cnt_a < 255) m_cnt_a++;
        if (m_cnt_b < 3) m_cnt_b++;
        if (!overlap_en) m_q.delete();
      end
    end
    if (cnt_clr) begin
      m_cnt_a = 0;
      m_cnt_b = 0;
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic b,
                     input logic ld = 0, input logic [2:0] p = 0,
                     input logic clr = 0);
    reset = r; seq_valid = v; seq_in = b;
    pat_load = ld; pat_in = p; cnt_clr = clr;
    @(posedge clock);
    model_step();
    #1;
    check("det_a", det_a, m_det);
    check("cnt_a", cnt_a, m_cnt_a);
    check("sat_a", sat_a, m_cnt_a == 255);
    check("det_b", det_b, m_det);
    check("cnt_b", cnt_b, m_cnt_b);
    check("sat_b", sat_b, m_cnt_b == 3);
  endtask

  // feed n valid bits of v, msb first
  task automatic feed(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) cyc(0, 1, v[i]);
  endtask

  initial begin
    // 1: overlap on defaults
    cyc(1, 0, 0);
    check("rst_det", det_a, 0);
    check("rst_cnt", cnt_a, 0);
    overlap_en = 1;
    feed(16'b10101, 5);
    check("t1_cnt", cnt_a, 2);

    // 2: non-overlap
    cyc(1, 0, 0);
    overlap_en = 0;
    feed(16'b10101, 5);
    check("t2_cnt1", cnt_a, 1);
    feed(16'b101, 3);
    check("t2_cnt2", cnt_a, 2);

    // 3: gaps with toggling data
    cyc(1, 0, 0);
    overlap_en = 1;
    cyc(0, 1, 1); cyc(0, 0, 0); cyc(0, 0, 1);
    cyc(0, 1, 0); cyc(0, 0, 1); cyc(0, 0, 0);
    cyc(0, 1, 1);
    check("t3_det", det_a, 1);
    cyc(0, 0, 1);
    check("t3_det_off", det_a, 0);

    // 4: load discards coincident sample
    cyc(1, 0, 0);
    feed(16'b10, 2);
    cyc(0, 1, 1, 1, 3'b110);
    check("t4_ld_det", det_a, 0);
    feed(16'b110, 3);
    check("t4_det", det_a, 1);
    feed(16'b101, 3);
    check("t4_old", det_a, 0);

    // 5: saturation on CNT_W=2, then clear on a match
    cyc(1, 0, 0);
    feed(16'b10101010101, 11);
    check("t5_cnt", cnt_b, 3);
    check("t5_sat", sat_b, 1);
    cyc(0, 1, 0);
    cyc(0, 1, 1, 0, 0, 1);
    check("t5_clr_det", det_b, 1);
    check("t5_clr_cnt", cnt_b, 0);
    check("t5_clr_sat", sat_b, 0);

    // 6: reset mid-sequence
    cyc(1, 0, 0);
    feed(16'b10, 2);
    cyc(1, 1, 1);
    check("t6_rst_cnt", cnt_a, 0);
    feed(16'b1, 1);
    check("t6_nodet", det_a, 0);
    feed(16'b01, 2);
    check("t6_det", det_a, 1);

    // random
    cyc(1, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) overlap_en = $urandom_range(0, 1) != 0;
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 9) < 7,
          $urandom_range(0, 1) != 0,
          $urandom_range(0, 39) == 0,
          3'($urandom_range(0, 7)),
          $urandom_range(0, 49) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
